// File: rtl/imem_arbiter.sv
// Arbiter sharing a single-port synchronous-read instruction memory between the fetch stage and the program loader.
// Optional fault counter output enabled by defining IMEM_ARB_FAULT_CNT_EN.
module imem_arbiter #(
  parameter int          MEM_SIZE  = 2048,
  parameter int          IDX_W     = 11,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_req,
  input  logic [63:0]      fetch_addr,
  output logic             fetch_gnt,
  output logic             fetch_valid,
  output logic [31:0]      fetch_instr,
  output logic             fetch_exc_en,
  output logic [3:0]       fetch_exc_code,
  output logic [63:0]      fetch_exc_val,
  input  logic             load_req,
  input  logic [63:0]      load_addr,
  input  logic [31:0]      load_data,
  output logic             load_gnt,
  output logic             load_err,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
`ifdef IMEM_ARB_FAULT_CNT_EN
  ,
  output logic [15:0]      fault_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
  typedef enum logic {WIN_FETCH = 1'b0, WIN_LOAD = 1'b1} winner_t;

  state_t      state_q, state_d;
  winner_t     last_q, last_d;
  logic        fault_q, fault_d;
  logic        code_q, code_d;
  logic [63:0] val_q, val_d;
  logic [31:0] instr_q, instr_d;

  logic        idle_s;
  logic        grant_load_s;
  logic        grant_fetch_s;
  logic [1:0]  fetch_chk_s;
  logic [1:0]  load_chk_s;
  logic [31:0] resp_instr_s;

  // Returns {bad, code}: code 0 = misaligned (wins), 1 = out of range.
  function automatic logic [1:0] check_addr(input logic [63:0] a);
    if (a[1:0] != 2'b00) begin
      check_addr = 2'b10;
    end else if (a[63:2] >= 62'(MEM_SIZE)) begin
      check_addr = 2'b11;
    end else begin
      check_addr = 2'b00;
    end
  endfunction

  assign fetch_chk_s = check_addr(fetch_addr);
  assign load_chk_s  = check_addr(load_addr);

  // Grants are combinational in IDLE and suppressed while reset is asserted.
  assign idle_s        = (state_q == IDLE) && !rst;
  assign grant_load_s  = idle_s && load_req && (!fetch_req || (last_q == WIN_FETCH));
  assign grant_fetch_s = idle_s && fetch_req && !grant_load_s;

  assign resp_instr_s   = fault_q ? NOP_INSTR : mem_rdata;
  assign fetch_valid    = (state_q == RESP);
  assign fetch_instr    = fetch_valid ? resp_instr_s : instr_q;
  assign fetch_exc_en   = fetch_valid && fault_q;
  assign fetch_exc_code = {3'b000, code_q};
  assign fetch_exc_val  = val_q;

  // State register and captured fetch response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= WIN_FETCH;
      fault_q <= 1'b0;
      code_q  <= 1'b0;
      val_q   <= 64'd0;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      val_q   <= val_d;
      instr_q <= instr_d;
    end
  end

  // Next-state, memory port and grant decode.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    fault_d   = fault_q;
    code_d    = code_q;
    val_d     = val_q;
    instr_d   = instr_q;
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    load_err  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = '0;
    mem_wdata = 32'd0;
    case (state_q)
      IDLE: begin
        if (grant_load_s) begin
          load_gnt = 1'b1;
          last_d   = WIN_LOAD;
          if (load_chk_s[1]) begin
            load_err = 1'b1;
          end else begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_idx   = load_addr[IDX_W+1:2];
            mem_wdata = load_data;
          end
        end else if (grant_fetch_s) begin
          fetch_gnt = 1'b1;
          last_d    = WIN_FETCH;
          state_d   = RESP;
          fault_d   = fetch_chk_s[1];
          code_d    = fetch_chk_s[1] & fetch_chk_s[0];
          val_d     = fetch_chk_s[1] ? fetch_addr : 64'd0;
          if (!fetch_chk_s[1]) begin
            mem_en  = 1'b1;
            mem_idx = fetch_addr[IDX_W+1:2];
          end else begin
            mem_en  = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
        instr_d = resp_instr_s;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef IMEM_ARB_FAULT_CNT_EN
  logic [15:0] fault_cnt_q;
  logic [1:0]  fault_inc_s;
  logic [16:0] fault_sum_s;

  assign fault_inc_s = {1'b0, fetch_exc_en} + {1'b0, load_err};
  assign fault_sum_s = {1'b0, fault_cnt_q} + {15'd0, fault_inc_s};
  assign fault_cnt   = fault_cnt_q;

  // Saturating fault counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_cnt_q <= 16'd0;
    end else begin
      fault_cnt_q <= fault_sum_s[16] ? 16'hFFFF : fault_sum_s[15:0];
    end
  end
`endif

endmodule
